// File: rtl/scalar_wb_arbiter.sv
// scalar_wb_arbiter: two-source writeback buffer and arbiter feeding the scalar register file write port
module scalar_wb_arbiter #(
  parameter int regSize     = 132,
  parameter int regQuantity = 16,
  parameter int selBits     = 4,
  parameter int starveLimit = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   aluValid,
  input  logic [selBits-1:0]     aluRd,
  input  logic [regSize-1:0]     aluData,
  output logic                   aluReady,
  input  logic                   memValid,
  input  logic [selBits-1:0]     memRd,
  input  logic [regSize-1:0]     memData,
  output logic                   memReady,
  output logic                   regWrEn,
  output logic [selBits-1:0]     regToWrite,
  output logic [regSize-1:0]     dataIn,
  output logic [regQuantity-1:0] pendMask
);
  localparam int cntBits = $clog2(starveLimit + 1);
  logic               aluFull, memFull;
  logic [selBits-1:0] aluBufRd, memBufRd;
  logic [regSize-1:0] aluBufData, memBufData;
  logic [cntBits-1:0] starveCnt;
  logic               starved, grantAlu, grantMem;
  // The ALU may only bypass the older memory result when it targets a different register.
  assign starved  = starveCnt == cntBits'(starveLimit) && aluBufRd != memBufRd;
  assign grantMem = memFull && !(aluFull && starved);
  assign grantAlu = aluFull && !grantMem;
  assign aluReady = reset && (!aluFull || grantAlu);
  assign memReady = reset && (!memFull || grantMem);
  assign pendMask = (regQuantity'(aluFull) << aluBufRd) | (regQuantity'(memFull) << memBufRd)
                  | (regQuantity'(regWrEn) << regToWrite);
  // ALU buffer: drained on grant, refilled on handshake (refill wins in the same cycle)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aluFull    <= 1'b0;
      aluBufRd   <= '0;
      aluBufData <= '0;
    end else if (aluValid && aluReady) begin
      aluFull    <= 1'b1;
      aluBufRd   <= aluRd;
      aluBufData <= aluData;
    end else if (grantAlu) begin
      aluFull    <= 1'b0;
    end
  end
  // Memory buffer: same drain/refill behaviour as the ALU buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memFull    <= 1'b0;
      memBufRd   <= '0;
      memBufData <= '0;
    end else if (memValid && memReady) begin
      memFull    <= 1'b1;
      memBufRd   <= memRd;
      memBufData <= memData;
    end else if (grantMem) begin
      memFull    <= 1'b0;
    end
  end
  // Count memory wins while the ALU waits; any ALU grant or empty ALU buffer resets it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) starveCnt <= '0;
    else if (!aluFull || grantAlu) starveCnt <= '0;
    else if (grantMem && starveCnt != cntBits'(starveLimit)) starveCnt <= starveCnt + 1'b1;
  end
  // Registered write port; select and data hold when idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regWrEn    <= 1'b0;
      regToWrite <= '0;
      dataIn     <= '0;
    end else begin
      regWrEn <= grantAlu || grantMem;
      if (grantAlu || grantMem) begin
        regToWrite <= grantMem ? memBufRd : aluBufRd;
        dataIn     <= grantMem ? memBufData : aluBufData;
      end
    end
  end
endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// tb_scalar_wb_arbiter: randomized check of scalar_wb_arbiter against a per-cycle behavioural model
module tb_scalar_wb_arbiter;
  localparam int W = 132, Q = 16, S = 4, LIM = 4;
  logic clk = 0, reset = 0;
  logic aluValid = 0, memValid = 0;
  logic [S-1:0] aluRd = 0, memRd = 0;
  logic [W-1:0] aluData = 0, memData = 0;
  logic aluReady, memReady, regWrEn;
  logic [S-1:0] regToWrite;
  logic [W-1:0] dataIn;
  logic [Q-1:0] pendMask;
  int vectors = 0, miscompares = 0;
  // model: buffer slots indexed 0 = ALU, 1 = memory
  bit mFull[2];
  int mRd[2];
  logic [W-1:0] mData[2];
  int mCnt;
  bit mWrEn;
  int mWrRd;
  logic [W-1:0] mWrData;

  scalar_wb_arbiter #(.regSize(W), .regQuantity(Q), .selBits(S), .starveLimit(LIM)) dut (
    .clk(clk), .reset(reset),
    .aluValid(aluValid), .aluRd(aluRd), .aluData(aluData), .aluReady(aluReady),
    .memValid(memValid), .memRd(memRd), .memData(memData), .memReady(memReady),
    .regWrEn(regWrEn), .regToWrite(regToWrite), .dataIn(dataIn), .pendMask(pendMask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, want %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rndData();
    return {4'($urandom), $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic modelClear();
    mFull[0] = 0; mFull[1] = 0; mRd[0] = 0; mRd[1] = 0; mData[0] = '0; mData[1] = '0;
    mCnt = 0; mWrEn = 0; mWrRd = 0; mWrData = '0;
  endtask

  task automatic checkOutputs();
    logic [Q-1:0] pm;
    pm = '0;
    for (int s = 0; s < 2; s++) if (mFull[s]) pm[mRd[s]] = 1'b1;
    if (mWrEn) pm[mWrRd] = 1'b1;
    check("regWrEn", 256'(regWrEn), 256'(mWrEn));
    check("regToWrite", 256'(regToWrite), 256'(mWrRd));
    check("dataIn", 256'(dataIn), 256'(mWrData));
    check("pendMask", 256'(pendMask), 256'(pm));
  endtask

  // one cycle starting at a negedge: drive, check readies, advance model, check registered outputs
  task automatic step(input bit aV, input int aR, input bit mV, input int mR);
    int g;
    bit rdy[2], val[2];
    int rin[2];
    logic [W-1:0] din[2];
    val[0] = aV; val[1] = mV; rin[0] = aR; rin[1] = mR; din[0] = rndData(); din[1] = rndData();
    aluValid = aV; aluRd = S'(aR); aluData = din[0];
    memValid = mV; memRd = S'(mR); memData = din[1];
    #1;
    if (mFull[0] && mFull[1]) g = (mCnt == LIM && mRd[0] != mRd[1]) ? 0 : 1;
    else if (mFull[1]) g = 1;
    else if (mFull[0]) g = 0;
    else g = -1;
    for (int s = 0; s < 2; s++) rdy[s] = !mFull[s] || g == s;
    check("aluReady", 256'(aluReady), 256'(rdy[0]));
    check("memReady", 256'(memReady), 256'(rdy[1]));
    mWrEn = g >= 0;
    if (g >= 0) begin mWrRd = mRd[g]; mWrData = mData[g]; end
    if (g == 0 || !mFull[0]) mCnt = 0;
    else if (g == 1 && mCnt < LIM) mCnt++;
    for (int s = 0; s < 2; s++) begin
      if (g == s) mFull[s] = 0;
      if (val[s] && rdy[s]) begin mFull[s] = 1; mRd[s] = rin[s]; mData[s] = din[s]; end
    end
    @(posedge clk);
    @(negedge clk);
    checkOutputs();
  endtask

  task automatic randomPhase(input int n, input int pA, input int pM, input int rdMax);
    for (int i = 0; i < n; i++)
      step($urandom_range(99) < pA, $urandom_range(rdMax), $urandom_range(99) < pM, $urandom_range(rdMax));
  endtask

  task automatic resetNow();
    reset = 0;
    #1;
    modelClear();
    check("rstAluReady", 256'(aluReady), 0);
    check("rstMemReady", 256'(memReady), 0);
    checkOutputs();
    @(posedge clk);
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    modelClear();
    #1;
    check("rstAluReady", 256'(aluReady), 0);
    check("rstMemReady", 256'(memReady), 0);
    checkOutputs();
    @(negedge clk);
    reset = 1;
    step(1, 3, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(1, 5, 1, 5);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(1, 7, 1, 2);
    for (int i = 0; i < 12; i++) step(0, 0, 1, 2);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(1, 2, 1, 2);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 2);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, i % 16, 0, 0);
    randomPhase(400, 70, 70, 15);
    randomPhase(400, 90, 95, 2);
    randomPhase(300, 40, 40, 1);
    step(1, 4, 1, 9);
    step(1, 6, 1, 8);
    resetNow();
    randomPhase(400, 80, 80, 3);
    step(1, 1, 1, 1);
    resetNow();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
